// File: rtl/parity_rx.sv
// Bit-serial framed receiver: start, DATA_W data bits LSB first, parity, stop; checks parity by XOR accumulation.
// Latency: word appears in the holding register the cycle after the stop-bit strobe.
// Backpressure: single-entry valid/ready holding register; a word completing while it is full and not drained is dropped and sets sticky overrun.
//
// Ports:
//   clk, reset_n          - rising-edge clock, synchronous active-low reset
//   bit_en, rx            - bit-time sample strobe and serial line (idles high)
//   out_data/out_perr     - received word and its parity error flag, qualified by out_valid
//   out_valid/out_ready   - holding register handshake
//   frame_err             - one-cycle pulse on a bad stop bit (only when PARITY_RX_STOP_CHECK_EN is defined, else tied 0)
//   overrun               - sticky, cleared only by reset
//
// Build option: define PARITY_RX_STOP_CHECK_EN to reject frames whose stop bit is 0.
module parity_rx #(
    parameter int DATA_W     = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              acc;
    logic              perr_pend;
    logic [DATA_W-1:0] shift_dat;

    logic stop_ok;
    logic commit_now;
    logic can_load;

`ifdef PARITY_RX_STOP_CHECK_EN
    logic frame_err_q;

    always_comb begin
        stop_ok = rx;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= bit_en && (state == S_STOP) && !rx;
        end
    end

    assign frame_err = frame_err_q;
`else
    // Stop bit is sampled (consumes its strobe) but never rejects the frame.
    always_comb begin
        stop_ok = 1'b1;
    end

    assign frame_err = 1'b0;
`endif

    always_comb begin
        commit_now = bit_en && (state == S_STOP) && stop_ok;
        // A held word being accepted this cycle frees the slot for the new one.
        can_load   = !out_valid || out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= 1'b0;
            perr_pend <= 1'b0;
            shift_dat <= '0;
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (!rx) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            acc   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_dat[cnt] <= rx;
                        acc            <= acc ^ rx;
                        if (cnt == LAST_BIT) begin
                            state <= S_PARITY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        perr_pend <= acc ^ rx ^ ODD_BIT;
                        state     <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end

            // Placed after the accept clear so a same-cycle commit keeps out_valid high.
            if (commit_now) begin
                if (can_load) begin
                    out_data  <= shift_dat;
                    out_perr  <= perr_pend;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
